// File: rtl/counter_event_logger_pkg.sv
// Shared constants for the counter event logger: event-type bit positions
// and the width of one logged entry.
package counter_logger_pkg;

  localparam int EVT_MATCH_BIT = 0;
  localparam int EVT_WRAP_BIT  = 1;
  localparam int EVT_TYPE_W    = 2;

  function automatic int evt_w(input int ts_w);
    return ts_w + EVT_TYPE_W;
  endfunction

endpackage

// File: rtl/counter_event_logger_evt_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head/valid/level.
// When full, a push is accepted only alongside a pop. When empty, the head holds its last value.
module evt_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_nxt_s;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          pop_ok_s, push_ok_s;

  always_comb begin
    pop_ok_s  = pop && valid_q;
    push_ok_s = push && ((level_q != LW'(DEPTH)) || pop_ok_s);
    rd_nxt_s  = rd_ptr_q + AW'(1'b1);

    if (push_ok_s && !pop_ok_s) begin
      level_d = level_q + LW'(1'b1);
    end else if (pop_ok_s && !push_ok_s) begin
      level_d = level_q - LW'(1'b1);
    end else begin
      level_d = level_q;
    end

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_nxt_s;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Next head: the stored successor, or the incoming word when it lands in an emptying FIFO.
    if (pop_ok_s) begin
      if (level_q > LW'(1'b1)) begin
        dout_d = mem_q[rd_nxt_s];
      end else if (push_ok_s) begin
        dout_d = push_data;
      end else begin
        dout_d = dout_q;
      end
    end else if (push_ok_s && !valid_q) begin
      dout_d = push_data;
    end else begin
      dout_d = dout_q;
    end

    valid_d = (level_d != {LW{1'b0}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      dout_q   <= {W{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
  assign level = level_q;
  assign full  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/counter_event_logger.sv
// Watches a counter for compare-match and wrap events, timestamps them and queues them
// in a FWFT FIFO drained over valid/ready. Wrap detection requires CNT_LOGGER_WRAP_EVT_EN.
module counter_event_logger
  import counter_logger_pkg::*;
#(
  parameter int               CNT_W   = 8,
  parameter int               TS_W    = 16,
  parameter int               DEPTH   = 8,
  parameter logic [CNT_W-1:0] CMP_RST = {CNT_W{1'b0}}
) (
  input  logic                        clk,
  input  logic                        RST,
  input  logic [CNT_W-1:0]            cnt_in,
  input  logic                        cmp_we,
  input  logic [CNT_W-1:0]            cmp_data,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [TS_W+1:0]             evt_data,
  output logic [$clog2(DEPTH):0]      fifo_level,
  output logic                        ovf,
  input  logic                        ovf_clr
);

  localparam int EW = evt_w(TS_W);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cmp_q, cmp_d;
  logic [TS_W-1:0]       ts_q, ts_d;
  logic                  primed_q, primed_d;
  logic                  ovf_q, ovf_d;
  logic                  changed_s;
  logic [EVT_TYPE_W-1:0] evt_type_s;
  logic                  push_s, pop_s, drop_s;
  logic [EW-1:0]         evt_word_s;
  logic                  fifo_full_s;

  always_comb begin
    cnt_d    = cnt_in;
    ts_d     = ts_q + TS_W'(1'b1);
    primed_d = 1'b1;

    if (cmp_we) begin
      cmp_d = cmp_data;
    end else begin
      cmp_d = cmp_q;
    end

    // Only a change of the observed value counts; the old compare value is used this cycle.
    changed_s                 = primed_q && (cnt_in != cnt_q);
    evt_type_s                = {EVT_TYPE_W{1'b0}};
    evt_type_s[EVT_MATCH_BIT] = changed_s && (cnt_in == cmp_q);
`ifdef CNT_LOGGER_WRAP_EVT_EN
    evt_type_s[EVT_WRAP_BIT]  = changed_s && (cnt_in < cnt_q);
`else
    evt_type_s[EVT_WRAP_BIT]  = 1'b0;
`endif

    push_s     = |evt_type_s;
    pop_s      = evt_valid && evt_ready;
    drop_s     = push_s && fifo_full_s && !pop_s;
    evt_word_s = {ts_q, evt_type_s};

    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cnt_q    <= {CNT_W{1'b0}};
      cmp_q    <= CMP_RST;
      ts_q     <= {TS_W{1'b0}};
      primed_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      cmp_q    <= cmp_d;
      ts_q     <= ts_d;
      primed_q <= primed_d;
      ovf_q    <= ovf_d;
    end
  end

  evt_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (RST),
    .push      (push_s),
    .push_data (evt_word_s),
    .pop       (pop_s),
    .dout      (evt_data),
    .valid     (evt_valid),
    .full      (fifo_full_s),
    .level     (fifo_level)
  );

  assign ovf = ovf_q;

endmodule

// File: tb/tb_counter_event_logger.sv
// Directed bench for counter_event_logger with a queue-based reference model checked every cycle.
module tb_counter_event_logger;

  localparam int CNT_W = 8;
  localparam int TS_W  = 16;
  localparam int DEPTH = 8;
  localparam int EW    = TS_W + 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             RST = 1'b1;
  logic [CNT_W-1:0] cnt_in = 8'h00;
  logic             cmp_we = 1'b0;
  logic [CNT_W-1:0] cmp_data = 8'h00;
  logic             evt_ready = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             evt_valid;
  logic [EW-1:0]    evt_data;
  logic [LW-1:0]    fifo_level;
  logic             ovf;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [EW-1:0]    q[$];
  logic [EW-1:0]    popped[$];
  logic [EW-1:0]    m_data;
  logic [CNT_W-1:0] m_prev, m_cmp;
  logic             m_primed, m_ovf;
  logic [TS_W-1:0]  m_ts;

  counter_event_logger #(
    .CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH), .CMP_RST(8'h00)
  ) dut (
    .clk(clk), .RST(RST), .cnt_in(cnt_in), .cmp_we(cmp_we), .cmp_data(cmp_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .fifo_level(fifo_level), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data = '0; m_prev = 8'h00; m_cmp = 8'h00;
    m_primed = 1'b0; m_ovf = 1'b0; m_ts = '0;
  endtask

  // Called at a falling edge with inputs for this cycle already applied.
  task automatic cyc();
    int sz;
    logic pop, match, wrap, evt, drop;
    chk("evt_valid", 32'(evt_valid), 32'(q.size() != 0));
    chk("evt_data", 32'(evt_data), 32'(m_data));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (evt_valid && evt_ready) popped.push_back(evt_data);

    sz = q.size();
    pop = (sz != 0) && evt_ready;
    match = 1'b0;
    wrap = 1'b0;
    if (m_primed && cnt_in != m_prev) begin
      match = (cnt_in == m_cmp);
`ifdef CNT_LOGGER_WRAP_EVT_EN
      wrap = (cnt_in < m_prev);
`endif
    end
    evt = match | wrap;
    drop = evt && (sz == DEPTH) && !pop;
    if (pop) void'(q.pop_front());
    if (evt && !drop) q.push_back({m_ts, wrap, match});
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (q.size() != 0) m_data = q[0];
    if (cmp_we) m_cmp = cmp_data;
    m_prev = cnt_in;
    m_primed = 1'b1;
    m_ts = m_ts + 16'd1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    RST = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_flags;
`ifdef CNT_LOGGER_WRAP_EVT_EN
    exp_flags = 2'b11;
`else
    exp_flags = 2'b01;
`endif
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: sweep 0..255 with compare 0x80; single match stamped ts=129
    cmp_we = 1'b1; cmp_data = 8'h80; evt_ready = 1'b1;
    cyc();
    cmp_we = 1'b0;
    for (int k = 0; k < 256; k++) begin
      cnt_in = 8'(k);
      cyc();
    end
    cyc();
    chk("sweep_count", 32'(popped.size()), 32'd1);
    if (popped.size() > 0) chk("sweep_entry", 32'(popped[0]), 32'h00000205);

    // 2: FE -> FF -> 00 with compare 0x00
    cmp_we = 1'b1; cmp_data = 8'h00;
    cyc();
    cmp_we = 1'b0;
    cnt_in = 8'hFE; cyc();
    cnt_in = 8'hFF; cyc();
    cyc();
    popped.delete();
    cnt_in = 8'h00; cyc();
    cyc();
    chk("wrap_count", 32'(popped.size()), 32'd1);
    if (popped.size() > 0) chk("wrap_flags", 32'(popped[0][1:0]), 32'(exp_flags));

    // 3: compare write coinciding with arrival of the new value uses old compare
    cmp_we = 1'b1; cmp_data = 8'h20; cyc();
    cmp_we = 1'b0;
    cnt_in = 8'h0F; cyc();
    popped.delete();
    cnt_in = 8'h10; cmp_we = 1'b1; cmp_data = 8'h10; cyc();
    cmp_we = 1'b0;
    cyc(); cyc();
    chk("cmpwe_no_evt", 32'(popped.size()), 32'd0);
    cnt_in = 8'h11; cyc();
    cnt_in = 8'h10; cyc();
    cyc();
    chk("cmpwe_next_evt", 32'(popped.size()), 32'd1);
    if (popped.size() > 0) chk("cmpwe_flags", 32'(popped[0][1:0]), 32'd1);

    // 4: 10 matches with no consumer -> full, overflow, in-order drain
    evt_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cnt_in = 8'h11; cyc();
      cnt_in = 8'h10; cyc();
    end
    cyc();
    chk("full_level", 32'(fifo_level), 32'd8);
    chk("full_ovf", 32'(ovf), 32'd1);
    ovf_clr = 1'b1; cyc();
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 32'd0);
    popped.delete();
    evt_ready = 1'b1;
    repeat (8) cyc();
    evt_ready = 1'b0;
    cyc();
    chk("drain_count", 32'(popped.size()), 32'd8);
    for (int i = 1; i < popped.size(); i++)
      chk("drain_ts_order", 32'(popped[i][EW-1:2] > popped[i-1][EW-1:2]), 32'd1);

    // 5: full FIFO with simultaneous push and pop, then drop under ovf_clr
    for (int i = 0; i < 8; i++) begin
      cnt_in = 8'h11; cyc();
      cnt_in = 8'h10; cyc();
    end
    cyc();
    chk("refill_level", 32'(fifo_level), 32'd8);
    cnt_in = 8'h11; cyc();
    cnt_in = 8'h10; evt_ready = 1'b1; cyc();
    evt_ready = 1'b0;
    cyc();
    chk("pushpop_level", 32'(fifo_level), 32'd8);
    chk("pushpop_ovf", 32'(ovf), 32'd0);
    cnt_in = 8'h11; cyc();
    cnt_in = 8'h10; ovf_clr = 1'b1; cyc();
    ovf_clr = 1'b0;
    cyc();
    chk("drop_beats_clr", 32'(ovf), 32'd1);

    // 6: asynchronous reset with 5 entries queued
    evt_ready = 1'b1;
    repeat (3) cyc();
    evt_ready = 1'b0;
    chk("pre_reset_level", 32'(fifo_level), 32'd5);
    cnt_in = 8'h00;
    #2;
    do_reset();
    evt_ready = 1'b1;
    repeat (4) cyc();
    chk("post_reset_level", 32'(fifo_level), 32'd0);
    chk("post_reset_valid", 32'(evt_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
